// File: rtl/pico_alu_mc.sv
// Multi-cycle signed ALU: PASS/ADD/ADDS/SUB in one cycle, MUL_LO/MUL_HI on an iterative shift-add engine.
// Latency: 1 cycle for single-cycle functions, N+2 cycles for multiplies (start sample to done).
// Backpressure: busy is high during MUL/FIN; a start seen while busy is dropped, not queued.
module pico_alu_mc #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   func,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         ovf,
    output logic         zero,
    output logic         illegal
);

    localparam logic [2:0] F_PASS_A = 3'b000;
    localparam logic [2:0] F_PASS_B = 3'b001;
    localparam logic [2:0] F_ADD    = 3'b010;
    localparam logic [2:0] F_MUL_LO = 3'b011;
    localparam logic [2:0] F_MUL_HI = 3'b100;
    localparam logic [2:0] F_ADDS   = 3'b101;
    localparam logic [2:0] F_SUB    = 3'b110;

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
    localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_FIN
    } state_t;

    // Captured multiply context: operand magnitudes plus the result sign and LO/HI select.
    typedef struct packed {
        logic         sign;
        logic         hi;
        logic [N-1:0] mcand;
        logic [N-1:0] mplier;
    } mul_ctx_t;

    state_t           state;
    state_t           state_nxt;
    mul_ctx_t         ctx;
    logic [CW-1:0]    count;
    logic [2*N-1:0]   acc;

    logic             is_mul;
    logic             accept_sc;
    logic             accept_mul;
    logic             load;
    logic [N-1:0]     sum;
    logic [N-1:0]     diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic [N-1:0]     sc_res;
    logic             sc_ovf;
    logic             sc_ill;
    logic [2*N-1:0]   partial;
    logic [2*N-1:0]   prod;
    logic             lo_ovf;
    logic [N-1:0]     ld_res;
    logic             ld_ovf;
    logic             ld_ill;

    function automatic logic [N-1:0] mag(input logic [N-1:0] v);
        return v[N-1] ? (~v + 1'b1) : v;
    endfunction

    assign is_mul     = (func == F_MUL_LO) || (func == F_MUL_HI);
    assign accept_sc  = (state == S_IDLE) && start && !is_mul;
    assign accept_mul = (state == S_IDLE) && start && is_mul;
    assign load       = accept_sc || (state == S_FIN);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept_mul) state_nxt = S_MUL;
            S_MUL:   if (count == LAST_CNT) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign sum     = a + b;
    assign diff    = a - b;
    assign add_ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
    assign sub_ovf = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        sc_ill = 1'b0;
        case (func)
            F_PASS_A: sc_res = a;
            F_PASS_B: sc_res = b;
            F_ADD: begin
                sc_res = sum;
                sc_ovf = add_ovf;
            end
            F_ADDS: begin
                // Overflow direction follows the common operand sign.
                sc_res = add_ovf ? (a[N-1] ? SAT_MIN : SAT_MAX) : sum;
                sc_ovf = add_ovf;
            end
            F_SUB: begin
                sc_res = diff;
                sc_ovf = sub_ovf;
            end
            F_MUL_LO, F_MUL_HI: sc_res = '0;
            default: sc_ill = 1'b1;
        endcase
    end

    assign partial = {{N{1'b0}}, ctx.mcand} << count;
    assign prod    = ctx.sign ? (~acc + 1'b1) : acc;
    // The low half is representable only if the top N+1 product bits are a pure sign extension.
    assign lo_ovf  = !((&prod[2*N-1:N-1]) || !(|prod[2*N-1:N-1]));

    always_comb begin
        ld_res = sc_res;
        ld_ovf = sc_ovf;
        ld_ill = sc_ill;
        if (state == S_FIN) begin
            ld_res = ctx.hi ? prod[2*N-1:N] : prod[N-1:0];
            ld_ovf = ctx.hi ? 1'b0 : lo_ovf;
            ld_ill = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done    <= 1'b0;
            result  <= '0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
            illegal <= 1'b0;
            count   <= '0;
            acc     <= '0;
            ctx     <= '0;
        end else begin
            done <= load;
            if (load) begin
                result  <= ld_res;
                ovf     <= ld_ovf;
                zero    <= (ld_res == '0);
                illegal <= ld_ill;
            end
            if (accept_mul) begin
                ctx.sign   <= a[N-1] ^ b[N-1];
                ctx.hi     <= (func == F_MUL_HI);
                ctx.mcand  <= mag(a);
                ctx.mplier <= mag(b);
                acc        <= '0;
                count      <= '0;
            end else if (state == S_MUL) begin
                if (ctx.mplier[count]) begin
                    acc <= acc + partial;
                end
                count <= (count == LAST_CNT) ? '0 : count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pico_alu_mc.sv
// Self-checking bench for pico_alu_mc: directed vector table, multi-cycle corner sequences,
// and randomized operations compared against an integer-arithmetic reference model.
module tb_pico_alu_mc;

    localparam int N    = 8;
    localparam int MAXV = (1 << (N - 1)) - 1;
    localparam int MINV = -(1 << (N - 1));

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   func;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         ovf;
    logic         zero;
    logic         illegal;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string        name;
        logic [2:0]   f;
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] r;
        logic         o;
        logic         z;
        logic         il;
    } vec_t;

    vec_t vt[$];

    pico_alu_mc #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .func    (func),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .ovf     (ovf),
        .zero    (zero),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic scramble();
        func = 3'($urandom_range(0, 7));
        a    = N'($urandom);
        b    = N'($urandom);
    endtask

    function automatic bit is_mul_f(input logic [2:0] f);
        return (f == 3'b011) || (f == 3'b100);
    endfunction

    // Reference: exact integer arithmetic on the signed operands.
    function automatic void model(input logic [2:0] f, input logic [N-1:0] x, input logic [N-1:0] y,
                                  output logic [N-1:0] r, output logic o, output logic il);
        int sx;
        int sy;
        int v;
        sx = int'($signed(x));
        sy = int'($signed(y));
        r  = '0;
        o  = 1'b0;
        il = 1'b0;
        case (f)
            3'b000: r = x;
            3'b001: r = y;
            3'b010: begin v = sx + sy; r = v[N-1:0]; o = (v > MAXV) || (v < MINV); end
            3'b011: begin v = sx * sy; r = v[N-1:0]; o = (v > MAXV) || (v < MINV); end
            3'b100: begin v = sx * sy; r = v[2*N-1:N]; end
            3'b101: begin
                v = sx + sy;
                o = (v > MAXV) || (v < MINV);
                if (v > MAXV) v = MAXV;
                if (v < MINV) v = MINV;
                r = v[N-1:0];
            end
            3'b110: begin v = sx - sy; r = v[N-1:0]; o = (v > MAXV) || (v < MINV); end
            default: il = 1'b1;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [N-1:0] x, input logic [N-1:0] y,
                          output int lat, output int bc);
        start = 1'b1;
        func  = f;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
        scramble();
        lat = 1;
        bc  = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bc++;
            step();
            lat++;
        end
    endtask

    task automatic check_op(input string nm, input logic [2:0] f, input logic [N-1:0] x, input logic [N-1:0] y,
                            input logic [N-1:0] er, input logic eo, input logic ez, input logic eil);
        int lat;
        int bc;
        run_op(f, x, y, lat, bc);
        check({nm, ".latency"}, lat, is_mul_f(f) ? N + 2 : 1);
        check({nm, ".busy_cycles"}, bc, is_mul_f(f) ? N + 1 : 0);
        check({nm, ".result"}, int'(result), int'(er));
        check({nm, ".ovf"}, int'(ovf), int'(eo));
        check({nm, ".zero"}, int'(zero), int'(ez));
        check({nm, ".illegal"}, int'(illegal), int'(eil));
        check({nm, ".busy_at_done"}, int'(busy), 0);
        step();
        check({nm, ".done_one_cycle"}, int'(done), 0);
    endtask

    initial begin
        int done_cnt;
        int done_at;
        int done_res;
        logic [2:0]   rf;
        logic [N-1:0] rx;
        logic [N-1:0] ry;
        logic [N-1:0] er;
        logic         eo;
        logic         eil;

        vt.push_back('{"add_ovf",    3'b010, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0});
        vt.push_back('{"adds_pos",   3'b101, 8'h7F, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b0});
        vt.push_back('{"adds_neg",   3'b101, 8'h80, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b0});
        vt.push_back('{"sub_zero",   3'b110, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0});
        vt.push_back('{"sub_ovf",    3'b110, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b0});
        vt.push_back('{"add_wrap0",  3'b010, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0});
        vt.push_back('{"pass_a",     3'b000, 8'h3C, 8'hAA, 8'h3C, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"pass_b",     3'b001, 8'h3C, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0});
        vt.push_back('{"reserved",   3'b111, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1'b1});
        vt.push_back('{"mul_lo_m3",  3'b011, 8'hFD, 8'h05, 8'hF1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"mul_hi_m3",  3'b100, 8'hFD, 8'h05, 8'hFF, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"mul_hi_min", 3'b100, 8'h80, 8'h80, 8'h40, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"mul_lo_min", 3'b011, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0});
        vt.push_back('{"mul_lo_m1",  3'b011, 8'h80, 8'h01, 8'h80, 1'b0, 1'b0, 1'b0});

        reset = 1'b1;
        start = 1'b0;
        func  = 3'b000;
        a     = '0;
        b     = '0;
        step();
        step();
        reset = 1'b0;
        check("reset.busy", int'(busy), 0);
        check("reset.done", int'(done), 0);
        check("reset.result", int'(result), 0);
        check("reset.flags", int'({ovf, zero, illegal}), 0);

        foreach (vt[i]) begin
            check_op(vt[i].name, vt[i].f, vt[i].x, vt[i].y, vt[i].r, vt[i].o, vt[i].z, vt[i].il);
        end

        // Starts during the busy window must be ignored.
        start = 1'b1; func = 3'b011; a = 8'h07; b = 8'h06;
        step();
        done_cnt = 0;
        done_at  = 0;
        done_res = 0;
        for (int k = 1; k <= 16; k++) begin
            if (done === 1'b1) begin
                done_cnt++;
                done_at  = k;
                done_res = int'(result);
            end
            scramble();
            start = (k <= N + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end
        check("busywin.done_count", done_cnt, 1);
        check("busywin.done_cycle", done_at, N + 2);
        check("busywin.result", done_res, 8'h2A);

        // Reset in the middle of a multiply aborts it silently.
        start = 1'b1; func = 3'b011; a = 8'h07; b = 8'h06;
        step();
        start = 1'b0;
        for (int k = 1; k < 5; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset.busy", int'(busy), 0);
        check("midreset.done", int'(done), 0);
        check("midreset.result", int'(result), 0);
        check("midreset.flags", int'({ovf, zero, illegal}), 0);
        done_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            if (done === 1'b1) done_cnt++;
            step();
        end
        check("midreset.no_done", done_cnt, 0);
        check_op("post_reset_add", 3'b010, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0);

        // Back-to-back single-cycle stream ending in the reserved code.
        start = 1'b1; func = 3'b000; a = 8'h11; b = 8'h99;
        step();
        check("stream0.done", int'(done), 1);
        check("stream0.result", int'(result), 8'h11);
        func = 3'b001; a = 8'h77; b = 8'h22;
        step();
        check("stream1.done", int'(done), 1);
        check("stream1.result", int'(result), 8'h22);
        func = 3'b010; a = 8'h01; b = 8'h02;
        step();
        check("stream2.done", int'(done), 1);
        check("stream2.result", int'(result), 8'h03);
        func = 3'b111; a = 8'h55; b = 8'h66;
        step();
        check("stream3.done", int'(done), 1);
        check("stream3.result", int'(result), 0);
        check("stream3.illegal", int'(illegal), 1);
        check("stream3.zero", int'(zero), 1);
        func = 3'b000; a = 8'h05; b = 8'h00;
        step();
        start = 1'b0;
        check("stream4.done", int'(done), 1);
        check("stream4.illegal", int'(illegal), 0);
        check("stream4.result", int'(result), 8'h05);
        step();
        check("stream_end.done", int'(done), 0);

        for (int i = 0; i < 150; i++) begin
            rf = 3'($urandom_range(0, 7));
            rx = N'($urandom);
            ry = N'($urandom);
            if (i % 10 == 0) rx = 8'h80;
            if (i % 13 == 0) ry = 8'h7F;
            model(rf, rx, ry, er, eo, eil);
            check_op($sformatf("rand%0d_f%0d", i, rf), rf, rx, ry, er, eo, (er == '0), eil);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
